// File: rtl/sram_arb.sv
// sram_arb: two-port arbiter and strobe sequencer for a shared asynchronous SRAM
module sram_arb #(
    parameter int ADDR_W     = 8,
    parameter int DATA_W     = 8,
    parameter int WAIT_CYC   = 1,
    parameter int FIXED_PRIO = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              p0_req,
    input  logic              p0_we,
    input  logic [ADDR_W-1:0] p0_addr,
    input  logic [DATA_W-1:0] p0_wdata,
    output logic              p0_gnt,
    output logic              p0_done,
    input  logic              p1_req,
    input  logic              p1_we,
    input  logic [ADDR_W-1:0] p1_addr,
    input  logic [DATA_W-1:0] p1_wdata,
    output logic              p1_gnt,
    output logic              p1_done,
    output logic [DATA_W-1:0] rdata,
    output logic [ADDR_W-1:0] sram_addr,
    output logic [DATA_W-1:0] sram_dq_out,
    input  logic [DATA_W-1:0] sram_dq_in,
    output logic              den,
    output logic              cen_n,
    output logic              oen_n,
    output logic              wen_n
);
    localparam logic [3:0] S_IDLE = 4'b0001, S_SETUP = 4'b0010, S_STROBE = 4'b0100, S_HOLD = 4'b1000;
    logic [3:0]        state_q, state_d, cnt_q, cnt_d;
    logic              we_q, we_d, win_q, win_d, rr_last_q, rr_last_d, win_sel;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d, rdata_q, rdata_d;
    logic              den_q, den_d, cen_n_q, cen_n_d, oen_n_q, oen_n_d, wen_n_q, wen_n_d;
    logic              g0_q, g0_d, g1_q, g1_d, d0_q, d0_d, d1_q, d1_d;
    // win_sel: 0 = port 0, 1 = port 1
    assign win_sel = (FIXED_PRIO != 0) ? !p0_req : ((p0_req && p1_req) ? !rr_last_q : p1_req);
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            we_q      <= 1'b0;
            win_q     <= 1'b0;
            rr_last_q <= 1'b1;
            addr_q    <= '0;
            wdata_q   <= '0;
            rdata_q   <= '0;
            den_q     <= 1'b0;
            cen_n_q   <= 1'b1;
            oen_n_q   <= 1'b1;
            wen_n_q   <= 1'b1;
            g0_q      <= 1'b0;
            g1_q      <= 1'b0;
            d0_q      <= 1'b0;
            d1_q      <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            we_q      <= we_d;
            win_q     <= win_d;
            rr_last_q <= rr_last_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            rdata_q   <= rdata_d;
            den_q     <= den_d;
            cen_n_q   <= cen_n_d;
            oen_n_q   <= oen_n_d;
            wen_n_q   <= wen_n_d;
            g0_q      <= g0_d;
            g1_q      <= g1_d;
            d0_q      <= d0_d;
            d1_q      <= d1_d;
        end
    end
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        we_d      = we_q;
        win_d     = win_q;
        rr_last_d = rr_last_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        rdata_d   = rdata_q;
        if (state_q[0] && (p0_req || p1_req)) begin
            state_d   = S_SETUP;
            win_d     = win_sel;
            rr_last_d = win_sel;
            we_d      = win_sel ? p1_we : p0_we;
            addr_d    = win_sel ? p1_addr : p0_addr;
            wdata_d   = win_sel ? p1_wdata : p0_wdata;
        end
        if (state_q[1]) begin
            state_d = S_STROBE;
            cnt_d   = 4'(WAIT_CYC - 1);
        end
        if (state_q[2]) begin
            cnt_d   = cnt_q - 4'd1;
            state_d = (cnt_q == 4'd0) ? S_HOLD : S_STROBE;
            rdata_d = (cnt_q == 4'd0 && !we_q) ? sram_dq_in : rdata_q;
        end
        if (state_q[3])
            state_d = S_IDLE;
    end
    // Outputs are decoded from the upcoming state so they register in step with it
    always_comb begin
        cen_n_d = !(state_d[1] || state_d[2] || (state_d[3] && we_d));
        oen_n_d = !(!we_d && (state_d[1] || state_d[2]));
        wen_n_d = !(we_d && state_d[2]);
        den_d   = we_d && (state_d[1] || state_d[2] || state_d[3]);
        g0_d    = state_d[1] && !win_d;
        g1_d    = state_d[1] && win_d;
        d0_d    = state_d[3] && !win_d;
        d1_d    = state_d[3] && win_d;
    end
    assign p0_gnt      = g0_q;
    assign p1_gnt      = g1_q;
    assign p0_done     = d0_q;
    assign p1_done     = d1_q;
    assign rdata       = rdata_q;
    assign sram_addr   = addr_q;
    assign sram_dq_out = wdata_q;
    assign den         = den_q;
    assign cen_n       = cen_n_q;
    assign oen_n       = oen_n_q;
    assign wen_n       = wen_n_q;
endmodule

// File: tb/tb_sram_arb.sv
// tb_sram_arb: directed checks of sram_arb in round-robin/WAIT_CYC=1 and fixed-priority/WAIT_CYC=3 builds
module tb_sram_arb;
    logic clk = 0, rst = 0;
    always #5 clk = ~clk;
    int n_tests = 0, n_fail = 0;

    logic       a_p0_req = 0, a_p0_we = 0, a_p1_req = 0, a_p1_we = 0;
    logic [7:0] a_p0_addr = 0, a_p0_wdata = 0, a_p1_addr = 0, a_p1_wdata = 0;
    logic       a_p0_gnt, a_p0_done, a_p1_gnt, a_p1_done, a_den, a_cen_n, a_oen_n, a_wen_n;
    logic [7:0] a_rdata, a_addr, a_dq_out, a_dq_in;
    logic [7:0] mem [256];

    logic       b_p0_req = 0, b_p0_we = 0, b_p1_req = 0, b_p1_we = 0;
    logic [7:0] b_p0_addr = 0, b_p0_wdata = 0, b_p1_addr = 0, b_p1_wdata = 0;
    logic       b_p0_gnt, b_p0_done, b_p1_gnt, b_p1_done, b_den, b_cen_n, b_oen_n, b_wen_n;
    logic [7:0] b_rdata, b_addr, b_dq_out, b_dq_in;

    sram_arb #(.ADDR_W(8), .DATA_W(8), .WAIT_CYC(1), .FIXED_PRIO(0)) dut_a (
        .clk(clk), .rst(rst),
        .p0_req(a_p0_req), .p0_we(a_p0_we), .p0_addr(a_p0_addr), .p0_wdata(a_p0_wdata),
        .p0_gnt(a_p0_gnt), .p0_done(a_p0_done),
        .p1_req(a_p1_req), .p1_we(a_p1_we), .p1_addr(a_p1_addr), .p1_wdata(a_p1_wdata),
        .p1_gnt(a_p1_gnt), .p1_done(a_p1_done),
        .rdata(a_rdata), .sram_addr(a_addr), .sram_dq_out(a_dq_out), .sram_dq_in(a_dq_in),
        .den(a_den), .cen_n(a_cen_n), .oen_n(a_oen_n), .wen_n(a_wen_n));

    sram_arb #(.ADDR_W(8), .DATA_W(8), .WAIT_CYC(3), .FIXED_PRIO(1)) dut_b (
        .clk(clk), .rst(rst),
        .p0_req(b_p0_req), .p0_we(b_p0_we), .p0_addr(b_p0_addr), .p0_wdata(b_p0_wdata),
        .p0_gnt(b_p0_gnt), .p0_done(b_p0_done),
        .p1_req(b_p1_req), .p1_we(b_p1_we), .p1_addr(b_p1_addr), .p1_wdata(b_p1_wdata),
        .p1_gnt(b_p1_gnt), .p1_done(b_p1_done),
        .rdata(b_rdata), .sram_addr(b_addr), .sram_dq_out(b_dq_out), .sram_dq_in(b_dq_in),
        .den(b_den), .cen_n(b_cen_n), .oen_n(b_oen_n), .wen_n(b_wen_n));

    // simple SRAM model for dut_a, a fixed address-derived pattern for dut_b
    initial for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    assign a_dq_in = mem[a_addr];
    always @(posedge clk) if (!a_wen_n && !a_cen_n) mem[a_addr] <= a_dq_out;
    assign b_dq_in = b_addr ^ 8'h5A;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n = 1);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        cyc(3);
        check("rst_hold_strobes", {a_cen_n, a_oen_n, a_wen_n, a_den}, 4'b1110);
        rst = 1;
        cyc(1);
        check("rst_strobes", {a_cen_n, a_oen_n, a_wen_n, a_den}, 4'b1110);
        check("rst_pulses", {a_p0_gnt, a_p1_gnt, a_p0_done, a_p1_done}, 4'b0000);
        check("rst_rdata", a_rdata, 8'h00);
        check("rst_b_strobes", {b_cen_n, b_oen_n, b_wen_n, b_den}, 4'b1110);

        // port 0 write 0x3C <= 0xA5
        a_p0_req = 1; a_p0_we = 1; a_p0_addr = 8'h3C; a_p0_wdata = 8'hA5;
        cyc(1);
        check("wr_c1_gnt", {a_p0_gnt, a_p1_gnt}, 2'b10);
        check("wr_c1_strb", {a_cen_n, a_oen_n, a_wen_n, a_den}, 4'b0111);
        a_p0_req = 0; a_p0_addr = 8'hFF; a_p0_wdata = 8'h00;
        cyc(1);
        check("wr_c2_strb", {a_cen_n, a_oen_n, a_wen_n, a_den}, 4'b0101);
        check("wr_c2_addr", {a_addr, a_dq_out}, 16'h3CA5);
        check("wr_c2_done", a_p0_done, 1'b0);
        cyc(1);
        check("wr_c3_done", {a_p0_done, a_p1_done}, 2'b10);
        check("wr_c3_strb", {a_cen_n, a_oen_n, a_wen_n, a_den}, 4'b0111);
        check("wr_c3_addr", {a_addr, a_dq_out}, 16'h3CA5);
        check("wr_rdata_kept", a_rdata, 8'h00);
        cyc(1);
        check("wr_c4_idle", {a_cen_n, a_oen_n, a_wen_n, a_den, a_p0_done}, 5'b11100);
        check("mem_written", mem[8'h3C], 8'hA5);

        // port 1 read 0x3C
        a_p1_req = 1; a_p1_we = 0; a_p1_addr = 8'h3C;
        cyc(1);
        check("rd_c1_gnt", {a_p0_gnt, a_p1_gnt}, 2'b01);
        check("rd_c1_strb", {a_cen_n, a_oen_n, a_wen_n, a_den}, 4'b0010);
        a_p1_req = 0;
        cyc(1);
        check("rd_c2_strb", {a_cen_n, a_oen_n, a_wen_n, a_den}, 4'b0010);
        cyc(1);
        check("rd_c3_done", {a_p0_done, a_p1_done}, 2'b01);
        check("rd_c3_strb", {a_cen_n, a_oen_n, a_wen_n, a_den}, 4'b1110);
        check("rd_c3_rdata", a_rdata, 8'hA5);
        cyc(2);

        // round-robin, both requesting continuously; port 1 was last so port 0 goes first
        a_p0_req = 1; a_p0_we = 0; a_p0_addr = 8'h10;
        a_p1_req = 1; a_p1_we = 0; a_p1_addr = 8'h20;
        for (int c = 1; c <= 16; c++) begin
            cyc(1);
            check($sformatf("rr_c%0d", c), {a_p0_gnt, a_p1_gnt},
                  {c == 1 || c == 9, c == 5 || c == 13});
            if (c == 16) begin a_p0_req = 0; a_p1_req = 0; end
        end
        cyc(1);
        check("rr_quiet", {a_p0_gnt, a_p1_gnt, a_cen_n}, 3'b001);

        // reset asserted during STROBE of a write
        a_p0_req = 1; a_p0_we = 1; a_p0_addr = 8'h44; a_p0_wdata = 8'h77;
        cyc(1);
        a_p0_req = 0;
        cyc(1);
        check("ar_pre_strb", {a_cen_n, a_wen_n, a_den}, 3'b001);
        rst = 0;
        #1;
        check("ar_now_strb", {a_cen_n, a_oen_n, a_wen_n, a_den}, 4'b1110);
        check("ar_now_addr", {a_addr, a_dq_out}, 16'h0000);
        cyc(1);
        check("ar_c3_done", {a_p0_done, a_p1_done}, 2'b00);
        rst = 1;
        cyc(1);
        check("ar_post_done", {a_p0_done, a_p1_done, a_cen_n}, 3'b001);
        check("ar_mem_kept", mem[8'h44], 8'h00);

        // fixed priority on dut_b (WAIT_CYC=3, period 6)
        b_p0_req = 1; b_p0_we = 1; b_p0_addr = 8'h01; b_p0_wdata = 8'h11;
        b_p1_req = 1; b_p1_we = 1; b_p1_addr = 8'h02; b_p1_wdata = 8'h22;
        for (int c = 1; c <= 13; c++) begin
            cyc(1);
            check($sformatf("fp_c%0d", c), {b_p0_gnt, b_p1_gnt},
                  {c == 1 || c == 7, c == 13});
            if (c == 11) b_p0_req = 0;
            if (c == 13) b_p1_req = 0;
        end
        cyc(5);
        check("fp_idle", {b_cen_n, b_p1_done}, 2'b10);

        // WAIT_CYC=3 read, address frozen after grant
        b_p0_req = 1; b_p0_we = 0; b_p0_addr = 8'h21;
        cyc(1);
        check("w3_c1_gnt", b_p0_gnt, 1'b1);
        b_p0_req = 0; b_p0_addr = 8'hFF;
        cyc(2);
        check("w3_c3_strb", {b_cen_n, b_oen_n, b_den, b_addr}, {3'b000, 8'h21});
        cyc(1);
        check("w3_c4_strb", {b_oen_n, b_p0_done}, 2'b00);
        cyc(1);
        check("w3_c5_done", {b_p0_done, b_p1_done, b_oen_n, b_cen_n}, 4'b1011);
        check("w3_c5_rdata", b_rdata, 8'h7B);
        cyc(1);
        check("w3_c6_done", b_p0_done, 1'b0);
        check("w3_rdata_hold", b_rdata, 8'h7B);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    // protocol invariants on every cycle
    always @(negedge clk) if (rst) begin
        if (a_p0_gnt && a_p1_gnt) check("a_dual_gnt", 1, 0);
        if (b_p0_gnt && b_p1_gnt) check("b_dual_gnt", 1, 0);
        if (a_p0_done && a_p1_done) check("a_dual_done", 1, 0);
        if (a_den && !a_oen_n) check("a_den_oen", 1, 0);
        if (b_den && !b_oen_n) check("b_den_oen", 1, 0);
        if (!a_wen_n && (a_cen_n || !a_den)) check("a_wen_ctx", 1, 0);
        if (!b_wen_n && (b_cen_n || !b_den)) check("b_wen_ctx", 1, 0);
    end
endmodule
